// File: rtl/axi_crossbar_slv_arb.sv
// Per-slave AW arbiter: round-robin grant into a one-entry AW register, with an
// order FIFO of granted master indices that steers W beats until each wlast.
module axi_crossbar_slv_arb #(
    parameter int NUM_MST  = 4,
    parameter int AWCH_W   = 53,
    parameter int WCH_W    = 47,
    parameter int OSTD_NUM = 4
) (
    input  logic                      i_aclk,
    input  logic                      i_srst,
    input  logic [NUM_MST-1:0]        i_awvalid,
    output logic [NUM_MST-1:0]        i_awready,
    input  logic [NUM_MST*AWCH_W-1:0] i_awch,
    input  logic [NUM_MST-1:0]        i_wvalid,
    output logic [NUM_MST-1:0]        i_wready,
    input  logic [NUM_MST*WCH_W-1:0]  i_wch,
    input  logic [NUM_MST-1:0]        i_wlast,
    output logic                      o_awvalid,
    input  logic                      o_awready,
    output logic [AWCH_W-1:0]         o_awch,
    output logic [$clog2(NUM_MST)-1:0] o_awmst,
    output logic                      o_wvalid,
    input  logic                      o_wready,
    output logic [WCH_W-1:0]          o_wch,
    output logic                      o_wlast
);
    localparam int MST_W = $clog2(NUM_MST);
    localparam int PTR_W = $clog2(OSTD_NUM);

    logic                awvalid_q, awvalid_d;
    logic [AWCH_W-1:0]   awch_q, awch_d;
    logic [MST_W-1:0]    awmst_q, awmst_d;
    logic [MST_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]      rd_ptr_q, rd_ptr_d;
    logic [MST_W-1:0]    ord_mem_q [OSTD_NUM];

    logic                aw_free, fifo_full, fifo_empty, arb_en, w_pop;
    logic                win_found;
    logic [MST_W-1:0]    win_idx, head;
    int                  scan_idx;

    assign aw_free    = !awvalid_q || o_awready;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head       = ord_mem_q[rd_ptr_q[PTR_W-1:0]];

    // First requester at or above the RR pointer, wrapping modulo NUM_MST.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int i = 0; i < NUM_MST; i++) begin
            scan_idx = (int'(rr_ptr_q) + i) % NUM_MST;
            if (!win_found && i_awvalid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = MST_W'(scan_idx);
            end
        end
    end

    assign arb_en    = !i_srst && aw_free && !fifo_full && win_found;
    assign i_awready = arb_en ? (NUM_MST'(1) << win_idx) : '0;

    always_comb begin
        awvalid_d = awvalid_q;
        awch_d    = awch_q;
        awmst_d   = awmst_q;
        rr_ptr_d  = rr_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (awvalid_q && o_awready) awvalid_d = 1'b0;
        if (arb_en) begin
            awvalid_d = 1'b1;
            awch_d    = i_awch[win_idx*AWCH_W +: AWCH_W];
            awmst_d   = win_idx;
            rr_ptr_d  = (win_idx == MST_W'(NUM_MST-1)) ? '0 : win_idx + 1'b1;
            wr_ptr_d  = wr_ptr_q + 1'b1;
        end
        if (w_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge i_aclk) begin
        if (i_srst) begin
            awvalid_q <= 1'b0;
            awch_q    <= '0;
            awmst_q   <= '0;
            rr_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            awvalid_q <= awvalid_d;
            awch_q    <= awch_d;
            awmst_q   <= awmst_d;
            rr_ptr_q  <= rr_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // Entry contents need no reset: the pointers alone define validity.
    always_ff @(posedge i_aclk) begin
        if (arb_en) ord_mem_q[wr_ptr_q[PTR_W-1:0]] <= win_idx;
    end

    assign o_awvalid = awvalid_q;
    assign o_awch    = awch_q;
    assign o_awmst   = awmst_q;

    always_comb begin
        o_wvalid = 1'b0;
        o_wch    = '0;
        o_wlast  = 1'b0;
        i_wready = '0;
        if (!fifo_empty) begin
            o_wvalid       = i_wvalid[head];
            o_wch          = i_wch[head*WCH_W +: WCH_W];
            o_wlast        = i_wlast[head];
            i_wready[head] = o_wready;
        end
    end

    assign w_pop = o_wvalid && o_wready && o_wlast;

endmodule

// File: tb/tb_axi_crossbar_slv_arb.sv
// Directed bench for axi_crossbar_slv_arb: inputs change on the falling edge,
// outputs are checked 1ns later with hand-computed expectations.
module tb_axi_crossbar_slv_arb;
    localparam int NUM_MST = 4;
    localparam int AWCH_W  = 53;
    localparam int WCH_W   = 47;
    localparam int OSTD    = 4;
    localparam int MST_W   = 2;

    logic                      clk = 1'b0;
    logic                      srst;
    logic [NUM_MST-1:0]        awvalid, awready, wvalid, wready, wlast;
    logic [NUM_MST*AWCH_W-1:0] awch_flat;
    logic [NUM_MST*WCH_W-1:0]  wch_flat;
    logic [AWCH_W-1:0]         awch_m [NUM_MST];
    logic [WCH_W-1:0]          wch_m  [NUM_MST];
    logic                      o_awvalid, o_awready, o_wvalid, o_wready, o_wlast;
    logic [AWCH_W-1:0]         o_awch;
    logic [MST_W-1:0]          o_awmst;
    logic [WCH_W-1:0]          o_wch;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar m = 0; m < NUM_MST; m++) begin : g_pack
        assign awch_flat[m*AWCH_W +: AWCH_W] = awch_m[m];
        assign wch_flat[m*WCH_W +: WCH_W]    = wch_m[m];
    end

    axi_crossbar_slv_arb #(
        .NUM_MST(NUM_MST), .AWCH_W(AWCH_W), .WCH_W(WCH_W), .OSTD_NUM(OSTD)
    ) dut (
        .i_aclk(clk), .i_srst(srst),
        .i_awvalid(awvalid), .i_awready(awready), .i_awch(awch_flat),
        .i_wvalid(wvalid), .i_wready(wready), .i_wch(wch_flat), .i_wlast(wlast),
        .o_awvalid(o_awvalid), .o_awready(o_awready), .o_awch(o_awch), .o_awmst(o_awmst),
        .o_wvalid(o_wvalid), .o_wready(o_wready), .o_wch(o_wch), .o_wlast(o_wlast)
    );

    task automatic clear_inputs();
        awvalid = '0; wvalid = '0; wlast = '0;
        o_awready = 1'b0; o_wready = 1'b0;
        for (int m = 0; m < NUM_MST; m++) begin
            awch_m[m] = AWCH_W'(m + 1);
            wch_m[m]  = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        clear_inputs();
        srst = 1'b1;
        awvalid = 4'b1111;
        @(negedge clk);
        #1;
        checks++;
        if ({o_awvalid, o_awmst, o_awch} !== {1'b1 ^ 1'b1, {MST_W{1'b0}}, {AWCH_W{1'b0}}}) begin
            errors++; $display("FAIL reset_aw: got v=%0b mst=%0d ch=%0h want 0", o_awvalid, o_awmst, o_awch);
        end
        checks++;
        if ({o_wvalid, o_wlast, o_wch, wready, awready} !== '0) begin
            errors++; $display("FAIL reset_w: got wv=%0b wl=%0b wch=%0h wr=%b awr=%b want 0",
                               o_wvalid, o_wlast, o_wch, wready, awready);
        end
        @(negedge clk);
        srst = 1'b0;
        awvalid = '0;
        #1;
        checks++;
        if ({o_awvalid, o_wvalid, awready, wready} !== '0) begin
            errors++; $display("FAIL reset_idle: got awv=%0b wv=%0b awr=%b wr=%b want 0",
                               o_awvalid, o_wvalid, awready, wready);
        end
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        awvalid = 4'b0100; awch_m[2] = 53'hA5;
        #1;
        checks++;
        if (awready !== 4'b0100) begin
            errors++; $display("FAIL single_awready: got %b want 0100", awready);
        end
        @(negedge clk);
        awvalid = '0; o_awready = 1'b1; o_wready = 1'b1;
        wvalid = 4'b0100; wlast = 4'b0100; wch_m[2] = 47'h33;
        #1;
        checks++;
        if ({o_awvalid, o_awmst, o_awch} !== {1'b1, 2'd2, 53'hA5}) begin
            errors++; $display("FAIL single_aw: got v=%0b mst=%0d ch=%0h want 1/2/a5", o_awvalid, o_awmst, o_awch);
        end
        checks++;
        if ({o_wvalid, o_wlast, o_wch, wready} !== {1'b1, 1'b1, 47'h33, 4'b0100}) begin
            errors++; $display("FAIL single_w: got wv=%0b wl=%0b wch=%0h wr=%b want 1/1/33/0100",
                               o_wvalid, o_wlast, o_wch, wready);
        end
        @(negedge clk);
        wvalid = '0; wlast = '0;
        #1;
        checks++;
        if ({o_awvalid, o_wvalid, wready} !== '0) begin
            errors++; $display("FAIL single_after: got awv=%0b wv=%0b wr=%b want 0", o_awvalid, o_wvalid, wready);
        end
    endtask

    task automatic test_round_robin();
        logic [NUM_MST-1:0] req [4];
        logic [NUM_MST-1:0] exp_rdy [4];
        logic [MST_W-1:0]   exp_mst [4];
        req     = '{4'b1011, 4'b1010, 4'b1001, 4'b0001};
        exp_rdy = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        exp_mst = '{2'd0, 2'd1, 2'd3, 2'd0};
        do_reset();
        o_awready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            awvalid = req[c];
            #1;
            checks++;
            if (awready !== exp_rdy[c]) begin
                errors++; $display("FAIL rr_grant%0d: got %b want %b", c, awready, exp_rdy[c]);
            end
            if (c > 0) begin
                checks++;
                if ({o_awvalid, o_awmst} !== {1'b1, exp_mst[c-1]}) begin
                    errors++; $display("FAIL rr_awmst%0d: got v=%0b mst=%0d want 1/%0d", c, o_awvalid, o_awmst, exp_mst[c-1]);
                end
            end
        end
        @(negedge clk);
        awvalid = '0;
        #1;
        checks++;
        if ({o_awvalid, o_awmst} !== {1'b1, exp_mst[3]}) begin
            errors++; $display("FAIL rr_last: got v=%0b mst=%0d want 1/0", o_awvalid, o_awmst);
        end
    endtask

    task automatic test_stall();
        do_reset();
        awch_m[0] = 53'h1_0000_0000_0001;
        awch_m[1] = 53'h0_ABCD_0000_0002;
        @(negedge clk);
        awvalid = 4'b0001;
        #1;
        checks++;
        if (awready !== 4'b0001) begin
            errors++; $display("FAIL stall_first: got %b want 0001", awready);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            awvalid = 4'b0010;
            #1;
            checks++;
            if ({awready, o_awvalid, o_awmst, o_awch} !== {4'b0000, 1'b1, 2'd0, 53'h1_0000_0000_0001}) begin
                errors++; $display("FAIL stall_hold%0d: got rdy=%b v=%0b mst=%0d ch=%0h", c, awready, o_awvalid, o_awmst, o_awch);
            end
        end
        @(negedge clk);
        awvalid = 4'b0011; o_awready = 1'b1;
        #1;
        checks++;
        if (awready !== 4'b0010) begin
            errors++; $display("FAIL stall_release: got %b want 0010", awready);
        end
        @(negedge clk);
        awvalid = '0;
        #1;
        checks++;
        if ({o_awvalid, o_awmst, o_awch} !== {1'b1, 2'd1, 53'h0_ABCD_0000_0002}) begin
            errors++; $display("FAIL stall_next: got v=%0b mst=%0d ch=%0h", o_awvalid, o_awmst, o_awch);
        end
    endtask

    task automatic test_fifo_full();
        logic [NUM_MST-1:0] exp_rdy [4];
        exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        do_reset();
        o_awready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            awvalid = 4'b1111;
            #1;
            checks++;
            if (awready !== exp_rdy[c]) begin
                errors++; $display("FAIL full_fill%0d: got %b want %b", c, awready, exp_rdy[c]);
            end
        end
        @(negedge clk);
        wvalid = 4'b0001; wlast = 4'b0001; o_wready = 1'b1; wch_m[0] = 47'h7777;
        #1;
        checks++;
        if (awready !== 4'b0000) begin
            errors++; $display("FAIL full_block: got %b want 0000", awready);
        end
        checks++;
        if ({o_wvalid, o_wlast, o_wch, wready} !== {1'b1, 1'b1, 47'h7777, 4'b0001}) begin
            errors++; $display("FAIL full_pop_w: got wv=%0b wl=%0b wch=%0h wr=%b", o_wvalid, o_wlast, o_wch, wready);
        end
        @(negedge clk);
        wvalid = '0; wlast = '0;
        #1;
        checks++;
        if (awready !== 4'b0001) begin
            errors++; $display("FAIL full_regrant: got %b want 0001", awready);
        end
        checks++;
        if (wready !== 4'b0010) begin
            errors++; $display("FAIL full_newhead: got %b want 0010", wready);
        end
        @(negedge clk);
        awvalid = '0;
    endtask

    task automatic test_w_order();
        logic exp_last;
        do_reset();
        o_awready = 1'b1; o_wready = 1'b1;
        @(negedge clk);
        awvalid = 4'b0010;
        #1;
        checks++;
        if (awready !== 4'b0010) begin
            errors++; $display("FAIL order_aw1: got %b want 0010", awready);
        end
        @(negedge clk);
        awvalid = 4'b0001;
        #1;
        checks++;
        if (awready !== 4'b0001) begin
            errors++; $display("FAIL order_aw0: got %b want 0001", awready);
        end
        @(negedge clk);
        awvalid = '0;
        wvalid = 4'b0001; wlast = 4'b0000; wch_m[0] = 47'h201;
        #1;
        checks++;
        if ({o_wvalid, wready} !== {1'b0, 4'b0010}) begin
            errors++; $display("FAIL order_stall: got wv=%0b wr=%b want 0/0010", o_wvalid, wready);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            wvalid = 4'b0011;
            wch_m[1] = 47'h100 + 47'(k);
            wlast = (k == 4) ? 4'b0010 : 4'b0000;
            exp_last = (k == 4);
            #1;
            checks++;
            if ({o_wvalid, o_wlast, o_wch, wready} !== {1'b1, exp_last, 47'h100 + 47'(k), 4'b0010}) begin
                errors++; $display("FAIL order_m1_beat%0d: got wv=%0b wl=%0b wch=%0h wr=%b", k, o_wvalid, o_wlast, o_wch, wready);
            end
        end
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            wvalid = 4'b0001;
            wch_m[0] = 47'h200 + 47'(k);
            wlast = (k == 2) ? 4'b0001 : 4'b0000;
            exp_last = (k == 2);
            #1;
            checks++;
            if ({o_wvalid, o_wlast, o_wch, wready} !== {1'b1, exp_last, 47'h200 + 47'(k), 4'b0001}) begin
                errors++; $display("FAIL order_m0_beat%0d: got wv=%0b wl=%0b wch=%0h wr=%b", k, o_wvalid, o_wlast, o_wch, wready);
            end
        end
        @(negedge clk);
        wvalid = 4'b0001; wlast = '0;
        #1;
        checks++;
        if ({o_wvalid, wready} !== {1'b0, 4'b0000}) begin
            errors++; $display("FAIL order_empty: got wv=%0b wr=%b want 0/0000", o_wvalid, wready);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        @(negedge clk);
        awvalid = 4'b0100; awch_m[2] = 53'h5A;
        #1;
        checks++;
        if (awready !== 4'b0100) begin
            errors++; $display("FAIL midrst_aw: got %b want 0100", awready);
        end
        @(negedge clk);
        awvalid = '0; o_wready = 1'b1; wvalid = 4'b0100; wch_m[2] = 47'h301;
        #1;
        checks++;
        if ({o_awvalid, o_wvalid, o_wch, wready} !== {1'b1, 1'b1, 47'h301, 4'b0100}) begin
            errors++; $display("FAIL midrst_beat1: got awv=%0b wv=%0b wch=%0h wr=%b", o_awvalid, o_wvalid, o_wch, wready);
        end
        @(negedge clk);
        wch_m[2] = 47'h302; srst = 1'b1;
        #1;
        checks++;
        if ({o_wvalid, o_wch} !== {1'b1, 47'h302}) begin
            errors++; $display("FAIL midrst_beat2: got wv=%0b wch=%0h", o_wvalid, o_wch);
        end
        @(negedge clk);
        srst = 1'b0; wch_m[2] = 47'h303;
        #1;
        checks++;
        if ({o_awvalid, o_awmst, o_awch, o_wvalid, wready, awready} !== '0) begin
            errors++; $display("FAIL midrst_cleared: got awv=%0b mst=%0d ch=%0h wv=%0b wr=%b awr=%b",
                               o_awvalid, o_awmst, o_awch, o_wvalid, wready, awready);
        end
        @(negedge clk);
        wvalid = '0; awvalid = 4'b1100;
        #1;
        checks++;
        if (awready !== 4'b0100) begin
            errors++; $display("FAIL midrst_ptr: got %b want 0100", awready);
        end
        @(negedge clk);
        awvalid = '0;
    endtask

    initial begin
        srst = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_fifo_full();
        test_w_order();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
